tx_fe_commit_seq: RTL and testbench

- Settings-bus sequencer placed between the host settings bus and the TX frontend settings port.
- Holds shadow copies of the frontend correction registers: I DC offset, Q DC offset, magnitude correction, phase correction and DAC mux.
- On a commit event, snapshots the shadow copies and writes all five to the frontend as one back-to-back burst, so corrections always change together.
- All other host writes pass through to the frontend bus, buffered one deep while a burst is running.

---
 rtl/tx_fe_commit_pkg.sv | 18 +
 rtl/tx_fe_commit_seq_settings_hold_buf.sv | 28 ++
 rtl/tx_fe_commit_seq.sv | 102 ++++++++++
 tb/tb_tx_fe_commit_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tx_fe_commit_pkg.sv
// tx_fe_commit_pkg: shared offsets, control bits, states and word widths for the commit sequencer
package tx_fe_commit_pkg;
  localparam logic [7:0] SH_OFS_IDCO = 8'd0;
  localparam logic [7:0] SH_OFS_QDCO = 8'd1;
  localparam logic [7:0] SH_OFS_MAG  = 8'd2;
  localparam logic [7:0] SH_OFS_PHS  = 8'd3;
  localparam logic [7:0] SH_OFS_MUX  = 8'd4;
  localparam logic [7:0] SH_OFS_CTRL = 8'd5;
  localparam logic [7:0] SH_OFS_CLR  = 8'd6;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_ARM    = 1;
  localparam int N_WORDS     = 5;
  localparam int SH_W [N_WORDS] = '{24, 24, 18, 18, 8};
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [31:0] width_mask(input int i);
    return (32'd1 << SH_W[i]) - 32'd1;
  endfunction
endpackage

// File: rtl/tx_fe_commit_seq_settings_hold_buf.sv
// settings_hold_buf: one-entry addr+data buffer; refills in the cycle it drains, flags a drop when full
module settings_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic [7:0]  addr,
  input  logic [31:0] data,
  output logic        full,
  output logic [7:0]  q_addr,
  output logic [31:0] q_data,
  output logic        drop
);
  assign drop = load & full & ~drain;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
    end else if (load && (!full || drain)) begin
      full   <= 1'b1;
      q_addr <= addr;
      q_data <= data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/tx_fe_commit_seq.sv
// tx_fe_commit_seq: shadows frontend correction regs and writes them as one atomic burst on commit
module tx_fe_commit_seq
  import tx_fe_commit_pkg::*;
#(
  parameter logic [7:0] SHADOW_BASE = 8'd0,
  parameter logic [7:0] FE_BASE     = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        commit_stb,
  input  logic        run,
  output logic        fe_stb,
  output logic [7:0]  fe_addr,
  output logic [31:0] fe_data,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] commit_count
);
  state_t      state, state_nx;
  logic [2:0]  idx;
  logic [31:0] shadow [N_WORDS];
  logic [31:0] snap   [N_WORDS];
  logic        pending, arm, run_q, last, start;
  logic        buf_full, buf_drop;
  logic [7:0]  buf_addr;
  logic [31:0] buf_data;
  logic [7:0]  ofs;
  logic        in_blk, commit;
  assign ofs    = set_addr - SHADOW_BASE;
  assign in_blk = ofs < 8'd7;
  assign commit = (set_stb && ofs == SH_OFS_CTRL && set_data[CTRL_COMMIT])
                | commit_stb | (run & ~run_q & arm);
  assign busy   = (state == BURST) | pending;
  always_comb begin
    last     = (state == BURST) && (idx == 3'd4);
    start    = (state == IDLE) ? (commit | pending) : (last & pending);
    state_nx = start ? BURST : (last ? IDLE : state);
  end
  // Burst words own the output register; the buffer only drains in IDLE
  settings_hold_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (set_stb & ~in_blk),
    .drain  (buf_full & (state != BURST)),
    .addr   (set_addr),
    .data   (set_data),
    .full   (buf_full),
    .q_addr (buf_addr),
    .q_data (buf_data),
    .drop   (buf_drop)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      pending      <= 1'b0;
      arm          <= 1'b0;
      run_q        <= 1'b0;
      overflow     <= 1'b0;
      commit_count <= '0;
      fe_stb       <= 1'b0;
      fe_addr      <= '0;
      fe_data      <= '0;
      for (int i = 0; i < N_WORDS; i++) begin
        shadow[i] <= '0;
        snap[i]   <= '0;
      end
    end else begin
      run_q <= run;
      for (int i = 0; i < N_WORDS; i++) begin
        if (set_stb && ofs == 8'(i)) shadow[i] <= set_data & width_mask(i);
        if (start) snap[i] <= shadow[i];
      end
      if (set_stb && ofs == SH_OFS_CTRL) arm <= set_data[CTRL_ARM];
      if (buf_drop) overflow <= 1'b1;
      else if (set_stb && ofs == SH_OFS_CLR) overflow <= 1'b0;
      pending <= start ? 1'b0 : (pending | (commit & (state == BURST)));
      idx     <= (start || last) ? 3'd0 : ((state == BURST) ? idx + 3'd1 : idx);
      if (last) commit_count <= commit_count + 16'd1;
      if (state == BURST) begin
        fe_stb  <= 1'b1;
        fe_addr <= FE_BASE + {5'd0, idx};
        fe_data <= snap[idx];
      end else if (buf_full) begin
        fe_stb  <= 1'b1;
        fe_addr <= buf_addr;
        fe_data <= buf_data;
      end else begin
        fe_stb <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_fe_commit_seq.sv
// tb_tx_fe_commit_seq: directed checks of commit bursts, run-edge arming, pass-through and reset abort
module tb_tx_fe_commit_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        set_stb = 1'b0, commit_stb = 1'b0, run = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        fe_stb, busy, overflow;
  logic [7:0]  fe_addr;
  logic [31:0] fe_data;
  logic [15:0] commit_count;
  logic [31:0] exp_w [5];
  int          n_run = 0, n_fail = 0;

  tx_fe_commit_seq dut (
    .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .commit_stb(commit_stb), .run(run), .fe_stb(fe_stb), .fe_addr(fe_addr), .fe_data(fe_data),
    .busy(busy), .overflow(overflow), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic burst_words(input string tag);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk({tag, "_stb"}, 32'(fe_stb), 32'd1);
      chk({tag, "_addr"}, 32'(fe_addr), 32'(k));
      chk({tag, "_data"}, fe_data, exp_w[k]);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      seen += int'(fe_stb);
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_stb", 32'(fe_stb), 0);
    chk("rst_addr", 32'(fe_addr), 0);
    chk("rst_data", fe_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cnt", 32'(commit_count), 0);

    // software commit; upper bits beyond each width are masked off
    exp_w = '{32'h000100, 32'hFFFF00, 32'h01000, 32'h3F000, 32'h10};
    wr(8'd0, 32'hFF000100); wr(8'd1, 32'h00FFFF00); wr(8'd2, 32'hFFF01000);
    wr(8'd3, 32'h0003F000); wr(8'd4, 32'hABCDEF10);
    chk("sw_idle_stb", 32'(fe_stb), 0);
    wr(8'd5, 32'h1);
    chk("sw_busy", 32'(busy), 1);
    chk("sw_nostb", 32'(fe_stb), 0);
    burst_words("sw");
    chk("sw_cnt", 32'(commit_count), 1);
    chk("sw_busy_end", 32'(busy), 0);
    tick();
    chk("sw_stb_end", 32'(fe_stb), 0);

    // armed run edge
    wr(8'd5, 32'h2);
    chk("arm_nocommit", 32'(busy), 0);
    run = 1'b1;
    tick();
    chk("run_busy", 32'(busy), 1);
    burst_words("run");
    chk("run_cnt", 32'(commit_count), 2);
    quiet("run_level", 10);
    wr(8'd5, 32'h0);
    run = 1'b0; tick(); run = 1'b1;
    quiet("run_disarm", 10);
    chk("run_disarm_cnt", 32'(commit_count), 2);
    run = 1'b0;

    // three commit_stb pulses -> two back-to-back bursts
    commit_stb = 1'b1;
    tick();
    commit_stb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      commit_stb = (i == 0 || i == 2);
      tick();
      commit_stb = 1'b0;
      chk("b2b_stb", 32'(fe_stb), 1);
      chk("b2b_addr", 32'(fe_addr), 32'(i % 5));
    end
    chk("b2b_cnt", 32'(commit_count), 4);
    chk("b2b_busy", 32'(busy), 0);
    tick();
    chk("b2b_end", 32'(fe_stb), 0);

    // shadow write during a burst is not torn into it
    wr(8'd5, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin set_stb = 1'b1; set_addr = 8'd0; set_data = 32'hFF123456; end
      tick();
      set_stb = 1'b0;
      chk("tear_data", fe_data, exp_w[i]);
    end
    exp_w[0] = 32'h123456;
    tick();
    wr(8'd5, 32'h1);
    burst_words("new");
    chk("new_cnt", 32'(commit_count), 6);
    tick();

    // pass-through in idle: two-cycle latency
    wr(8'h20, 32'hCAFEBABE);
    chk("pt_lat1", 32'(fe_stb), 0);
    tick();
    chk("pt_stb", 32'(fe_stb), 1);
    chk("pt_addr", 32'(fe_addr), 32'h20);
    chk("pt_data", fe_data, 32'hCAFEBABE);
    tick();
    chk("pt_end", 32'(fe_stb), 0);

    // two pass-through writes during a burst: first held, second dropped
    wr(8'd5, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin set_stb = 1'b1; set_addr = 8'h21 + 8'(i); set_data = 32'h5A00 + 32'(i); end
      tick();
      set_stb = 1'b0;
      chk("ptb_addr", 32'(fe_addr), 32'(i));
    end
    chk("ptb_ovf", 32'(overflow), 1);
    tick();
    chk("ptb_stb", 32'(fe_stb), 1);
    chk("ptb_addr1", 32'(fe_addr), 32'h21);
    chk("ptb_data1", fe_data, 32'h5A00);
    tick();
    chk("ptb_drop", 32'(fe_stb), 0);
    wr(8'd6, 32'h0);
    chk("ovf_clr", 32'(overflow), 0);

    // reset mid-burst at idx 2
    wr(8'd5, 32'h1);
    tick(); tick(); tick();
    chk("pre_rst_addr", 32'(fe_addr), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_stb", 32'(fe_stb), 0);
    chk("arst_addr", 32'(fe_addr), 0);
    chk("arst_data", fe_data, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(commit_count), 0);
    tick();
    rst_n = 1'b1;
    quiet("post_rst", 8);
    chk("post_rst_cnt", 32'(commit_count), 0);
    exp_w = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    wr(8'd5, 32'h1);
    burst_words("zero");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
